delay_prog: RTL and testbench
=============================

DELAY_PROG -- requirements
Module: delay_prog

Interface
REQ-001 Parameter WIDTH, default 20, data word width in bits.
REQ-002 Parameter MAX_DEPTH, default 8, number of storage stages and maximum delay (power of two, >=2).
REQ-003 Parameter SEL_W, default 3, width of the delay-select field; SHALL equal log2(MAX_DEPTH).
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 en  input  1  clock enable; chain advances one stage per cycle with en=1.
REQ-007 clr  input  1  synchronous clear of stored data and status.
REQ-008 dly_ld  input  1  load strobe for dly.
REQ-009 dly  input  SEL_W  requested delay minus one (delay = dly+1, range 1..MAX_DEPTH).
REQ-010 in_valid  input  1  qualifies in.
REQ-011 in  input  WIDTH  data sample.
REQ-012 out  output  WIDTH  delayed sample.
REQ-013 out_valid  output  1  out carries a valid delayed sample.
REQ-014 primed  output  1  chain holds at least (current delay) valid samples since last reset/clear.
REQ-015 dly_cur  output  SEL_W  currently applied delay-select value.

Function
REQ-016 Storage SHALL be MAX_DEPTH stages of {valid bit, WIDTH data}; stage 0 captures {in_valid, in}, stage k captures stage k-1.
REQ-017 Stages SHALL shift only on cycles with en=1 and clr=0; with en=0 all state holds.
REQ-018 Shift SHALL occur with en=1 regardless of in_valid; an invalid input enters as valid=0, data=in (not gated).
REQ-019 out and out_valid SHALL be the data and valid bit of stage dly_cur (combinational tap of registers, no extra register).
REQ-020 Latency SHALL be exactly dly_cur+1 enabled cycles from in to out; en=0 cycles do not count.
REQ-021 dly_cur SHALL load dly on a cycle with dly_ld=1, independent of en; dly_ld has priority over hold, and is ignored when clr=1.
REQ-022 Delay change SHALL NOT disturb stored data; the output switches to the new tap on the cycle after load.
REQ-023 fill_cnt (internal, SEL_W+1 bits) SHALL increment by 1 on each shift with in_valid=1, saturating at MAX_DEPTH; it never decrements except by clear/reset.
REQ-024 primed SHALL equal (fill_cnt >= dly_cur+1), evaluated combinationally from registered values, so a delay load updates primed in the same cycle as dly_cur.
REQ-025 clr=1 SHALL zero all stage data, stage valid bits and fill_cnt at the next edge; clr has priority over en; dly_cur is retained.
REQ-026 Simultaneous clr and dly_ld: clear SHALL take effect, dly load ignored.
REQ-027 Data SHALL pass bit-exact; no arithmetic, sign extension or truncation.

Reset
REQ-028 rst_n=0 SHALL immediately force all stage data and valid bits to 0, fill_cnt to 0, dly_cur to MAX_DEPTH-1.
REQ-029 During reset: out=0, out_valid=0, primed=0, dly_cur=MAX_DEPTH-1.
REQ-030 Reset asserted mid-operation SHALL discard all in-flight samples; the first sample after release arrives after the full dly_cur+1 enabled cycles.
REQ-031 Reset deassertion SHALL be used synchronised to clk by the integrator; the block's only requirement is that no edge coincides with release.

Verification
REQ-032 Default delay: reset, en=1, in_valid=1, in=1,2,3,... per cycle -> out=0/out_valid=0 for 8 cycles, then out=1 on the 8th edge after first sample, primed rises together with first out_valid.
REQ-033 Delay 5 (dly=4, dly_ld pulse): stream 0xABCDE then counting -> 0xABCDE appears at out exactly 5 enabled cycles later; dly_cur=4.
REQ-034 Enable gaps: dly=2, en toggled 1,0,0,1,1 with in=0x00011 on first cycle -> out=0x00011 after the third en=1 cycle, held through en=0 cycles.
REQ-035 Live delay change: fill chain with 1..8 at dly=7, pulse dly_ld with dly=1 -> next cycle out=stage1 value (7), out_valid=1, primed=1, no data lost in chain.
REQ-036 Clear and simultaneous events: assert clr with dly_ld=1, dly=0 while full -> next cycle out=0, out_valid=0, primed=0, dly_cur unchanged.
REQ-037 Async reset mid-stream: drop rst_n between edges while out_valid=1 -> out, out_valid, primed go 0 before next edge; dly_cur=MAX_DEPTH-1; sample latency after release is MAX_DEPTH enabled cycles.

Source files
------------

// File: rtl/delay_prog.sv
// Programmable-depth delay line with per-stage valid bits.
// The output tap selects one register stage, so the delay can change without losing data.
module delay_prog #(
    parameter int WIDTH     = 20,
    parameter int MAX_DEPTH = 8,
    parameter int SEL_W     = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             dly_ld,
    input  logic [SEL_W-1:0] dly,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic             primed,
    output logic [SEL_W-1:0] dly_cur
);

    localparam logic [SEL_W-1:0] DLY_RST  = SEL_W'(MAX_DEPTH - 1);
    localparam logic [SEL_W:0]   FILL_MAX = (SEL_W + 1)'(MAX_DEPTH);
    localparam logic [SEL_W:0]   ONE      = (SEL_W + 1)'(1);

    logic [WIDTH-1:0]     data_q [MAX_DEPTH];
    logic [MAX_DEPTH-1:0] vld_q;
    logic [SEL_W:0]       fill_cnt;
    logic [SEL_W-1:0]     dly_q;
    logic [SEL_W:0]       need;
    logic                 shift;

    assign shift = en & ~clr;

    // Data stages: clear wins over shift; invalid samples still move their data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < MAX_DEPTH; k++) begin
                data_q[k] <= '0;
            end
        end else if (clr) begin
            for (int k = 0; k < MAX_DEPTH; k++) begin
                data_q[k] <= '0;
            end
        end else if (shift) begin
            data_q[0] <= in;
            for (int k = 1; k < MAX_DEPTH; k++) begin
                data_q[k] <= data_q[k-1];
            end
        end
    end

    // Valid bits travel alongside the data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
        end else if (clr) begin
            vld_q <= '0;
        end else if (shift) begin
            vld_q <= {vld_q[MAX_DEPTH-2:0], in_valid};
        end
    end

    // Delay select loads independent of enable; a clear in the same cycle blocks it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dly_q <= DLY_RST;
        end else if (dly_ld && !clr) begin
            dly_q <= dly;
        end
    end

    // Count of valid samples accepted since reset/clear, saturating at chain depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_cnt <= '0;
        end else if (clr) begin
            fill_cnt <= '0;
        end else if (shift && in_valid && fill_cnt != FILL_MAX) begin
            fill_cnt <= fill_cnt + ONE;
        end
    end

    assign need      = {1'b0, dly_q} + ONE;
    assign primed    = (fill_cnt >= need);
    assign out       = data_q[dly_q];
    assign out_valid = vld_q[dly_q];
    assign dly_cur   = dly_q;

endmodule

// File: tb/tb_delay_prog.sv
// Scoreboard bench for delay_prog: samples are queued with their due
// enabled-cycle index and popped when the DUT presents a valid output.
module tb_delay_prog;

    localparam int W = 20;
    localparam int D = 8;
    localparam int S = 3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0;
    logic         clr = 1'b0;
    logic         dly_ld = 1'b0;
    logic         in_valid = 1'b0;
    logic [S-1:0] dly = '0;
    logic [W-1:0] din = '0;
    logic [W-1:0] dout;
    logic         out_valid;
    logic         primed;
    logic [S-1:0] dly_cur;

    typedef struct {
        logic [W-1:0] data;
        int           due;
    } sb_t;

    sb_t sbq[$];
    int  checks = 0;
    int  failures = 0;
    int  ecnt = 0;
    int  fill_m = 0;
    int  dly_m = D - 1;
    bit  sb_on = 1'b1;

    always #5 clk = ~clk;

    delay_prog #(
        .WIDTH(W),
        .MAX_DEPTH(D),
        .SEL_W(S)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .en(en),
        .clr(clr),
        .dly_ld(dly_ld),
        .dly(dly),
        .in_valid(in_valid),
        .in(din),
        .out(dout),
        .out_valid(out_valid),
        .primed(primed),
        .dly_cur(dly_cur)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic e, input logic v, input logic [W-1:0] d,
                       input logic ld, input logic [S-1:0] nd,
                       input logic c);
        sb_t it;
        bit  sh;
        en = e;
        in_valid = v;
        din = d;
        dly_ld = ld;
        dly = nd;
        clr = c;
        sh = e && !c;
        if (ld && !c) dly_m = int'(nd);
        if (sh && v && sb_on) begin
            it.data = d;
            it.due = ecnt + 1 + dly_m;
            sbq.push_back(it);
        end
        @(posedge clk);
        #1;
        en = 1'b0;
        dly_ld = 1'b0;
        clr = 1'b0;
        if (c) begin
            fill_m = 0;
            sbq.delete();
        end
        if (sh) begin
            ecnt++;
            if (v && fill_m < D) fill_m++;
        end
        chk("dly_cur", 32'(dly_cur), 32'(dly_m));
        chk("primed", 32'(primed), 32'(fill_m >= dly_m + 1));
        if (c) begin
            chk("clr_out", 32'(dout), 0);
            chk("clr_vld", 32'(out_valid), 0);
        end
        if (sh && sb_on) begin
            if (out_valid) begin
                if (sbq.size() == 0) begin
                    chk("sb_extra", 32'(out_valid), 0);
                end else begin
                    it = sbq.pop_front();
                    chk("sb_data", 32'(dout), 32'(it.data));
                    chk("sb_lat", 32'(ecnt), 32'(it.due));
                end
            end else if (sbq.size() > 0 && sbq[0].due <= ecnt) begin
                chk("sb_miss", 32'(out_valid), 1);
                void'(sbq.pop_front());
            end
        end
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_out", 32'(dout), 0);
        chk("rst_vld", 32'(out_valid), 0);
        chk("rst_prm", 32'(primed), 0);
        chk("rst_dly", 32'(dly_cur), 7);
        #5 rst_n = 1'b1;

        // Default delay of 8
        for (int i = 1; i <= 12; i++) begin
            cyc(1, 1, W'(i), 0, 0, 0);
            if (i == 7) begin
                chk("def_pre_vld", 32'(out_valid), 0);
                chk("def_pre_prm", 32'(primed), 0);
            end
            if (i == 8) begin
                chk("def_out", 32'(dout), 1);
                chk("def_vld", 32'(out_valid), 1);
                chk("def_prm", 32'(primed), 1);
            end
        end
        cyc(0, 0, 0, 0, 0, 1);

        // Delay 5
        cyc(0, 0, 0, 1, 4, 0);
        cyc(1, 1, 20'hABCDE, 0, 0, 0);
        for (int i = 1; i <= 7; i++) begin
            cyc(1, 1, W'(i), 0, 0, 0);
            if (i == 4) chk("d5_out", 32'(dout), 32'h000ABCDE);
        end
        cyc(0, 0, 0, 0, 0, 1);

        // Enable gaps at delay 3; invalid input data is not gated
        cyc(0, 0, 0, 1, 2, 0);
        cyc(1, 1, 20'h00011, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(1, 0, 20'h00055, 0, 0, 0);
        cyc(1, 0, 20'h00000, 0, 0, 0);
        chk("gap_out", 32'(dout), 32'h11);
        chk("gap_vld", 32'(out_valid), 1);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("gap_hold", 32'(dout), 32'h11);
        cyc(1, 0, 0, 0, 0, 0);
        chk("inv_data", 32'(dout), 32'h55);
        chk("inv_vld", 32'(out_valid), 0);
        cyc(0, 0, 0, 0, 0, 1);

        // Live delay change
        sb_on = 1'b0;
        cyc(0, 0, 0, 1, 7, 0);
        for (int i = 1; i <= 8; i++) cyc(1, 1, W'(i), 0, 0, 0);
        chk("live_full", 32'(dout), 1);
        cyc(0, 0, 0, 1, 1, 0);
        chk("live_out", 32'(dout), 7);
        chk("live_vld", 32'(out_valid), 1);
        chk("live_prm", 32'(primed), 1);
        cyc(0, 0, 0, 1, 7, 0);
        chk("live_back", 32'(dout), 1);

        // Clear with simultaneous load
        cyc(1, 1, 20'h12345, 1, 0, 1);
        chk("clr_prm", 32'(primed), 0);
        chk("clr_dly", 32'(dly_cur), 7);
        sb_on = 1'b1;

        // Async reset mid-stream
        cyc(0, 0, 0, 1, 3, 0);
        for (int i = 1; i <= 6; i++) cyc(1, 1, W'(i + 32), 0, 0, 0);
        chk("pre_rst_vld", 32'(out_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out", 32'(dout), 0);
        chk("arst_vld", 32'(out_valid), 0);
        chk("arst_prm", 32'(primed), 0);
        chk("arst_dly", 32'(dly_cur), 7);
        fill_m = 0;
        dly_m = D - 1;
        sbq.delete();
        #2 rst_n = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            cyc(1, 1, W'(i), 0, 0, 0);
            if (i == 7) chk("post_rst_pre", 32'(out_valid), 0);
            if (i == 8) begin
                chk("post_rst_out", 32'(dout), 1);
                chk("post_rst_vld", 32'(out_valid), 1);
            end
        end

        // Random traffic at delay 6
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 1, 5, 0);
        for (int i = 0; i < 300; i++) begin
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                W'($urandom), 0, 0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
